// File: rtl/la_axi_pkg.sv
// Shared AXI definitions: burst and response encodings, responder FSM states,
// and the WRAP burst length legality helper.
package la_axi_pkg;

  localparam logic [1:0] BurstFixed = 2'd0;
  localparam logic [1:0] BurstIncr  = 2'd1;
  localparam logic [1:0] BurstWrap  = 2'd2;

  localparam logic [1:0] RespOkay   = 2'd0;
  localparam logic [1:0] RespSlverr = 2'd2;
  localparam logic [1:0] RespDecerr = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StRdBeat,
    StWrData,
    StWrResp
  } axi_state_e;

  // WRAP bursts are only meaningful for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/la_axi_bus.sv
// AXI3-style bus bundle between the 2x1 crossbar and memory endpoints.
interface LA_AXI_BUS;
  logic [3:0]  aw_id;
  logic [31:0] aw_addr;
  logic [3:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [1:0]  aw_lock;
  logic [3:0]  aw_cache;
  logic [2:0]  aw_prot;
  logic [3:0]  aw_qos;
  logic        aw_valid;
  logic        aw_ready;

  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;
  logic        w_valid;
  logic        w_ready;

  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;

  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [3:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [1:0]  ar_lock;
  logic [3:0]  ar_cache;
  logic [2:0]  ar_prot;
  logic [3:0]  ar_qos;
  logic        ar_valid;
  logic        ar_ready;

  logic [3:0]  r_id;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        r_valid;
  logic        r_ready;

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
    input  aw_valid, w_data, w_strb, w_last, w_valid, b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
    input  ar_valid, r_ready,
    output aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid
  );

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
    output aw_valid, w_data, w_strb, w_last, w_valid, b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
    output ar_valid, r_ready,
    input  aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts.
module axi_burst_addr_gen
  import la_axi_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [2:0]  size_i,
  input  logic [3:0]  len_i,
  input  logic [1:0]  burst_i,
  output logic [31:0] next_addr_o
);

  logic [31:0] incr;
  logic [31:0] boundary;
  logic [31:0] mask;
  logic [31:0] seq;

  // Select next address by burst type; illegal WRAP lengths and the reserved
  // encoding fall back to INCR.
  always_comb begin
    incr     = 32'd1 << size_i;
    boundary = ({28'd0, len_i} + 32'd1) << size_i;
    mask     = boundary - 32'd1;
    seq      = addr_i + incr;
    case (burst_i)
      BurstFixed: next_addr_o = addr_i;
      BurstWrap:  next_addr_o = wrap_len_ok(len_i) ? ((addr_i & ~mask) | (seq & mask)) : seq;
      default:    next_addr_o = seq;
    endcase
  end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI3 slave memory endpoint: one transaction at a time, single and burst
// reads/writes out of an inline word array, DECERR for out-of-range beats.
// Optional random back-pressure under AXI_SRAM_RAND_STALL_EN.
module axi_sram_responder #(
  parameter int unsigned DEPTH     = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
  parameter int unsigned RD_LAT    = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic      clk,
  input logic      rst,
  LA_AXI_BUS.Slave mem_bus
);
  import la_axi_pkg::*;

  localparam int unsigned IdxW      = $clog2(DEPTH);
  localparam logic [31:0] SpanBytes = 32'(DEPTH) << 2;

  axi_state_e state_q, state_d;
  logic [3:0]  id_q, id_d, len_q, len_d, beat_q, beat_d, cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, next_addr;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic        last_grant_q, last_grant_d;  // 1: most recent grant went to AR
  logic        decerr_q, decerr_d, slverr_q, slverr_d;

  logic            stall;
  logic [31:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] word_idx;
  logic            ar_ready, aw_ready, w_ready, r_valid, b_valid;
  logic            r_hs, w_hs, mem_we;

  logic [31:0] mem [DEPTH];

  axi_burst_addr_gen u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && (offset < SpanBytes);
  assign word_idx = offset[IdxW+1:2];

`ifdef AXI_SRAM_RAND_STALL_EN
  logic [15:0] lfsr_q;
  logic        r_hold_q;

  // Stall LFSR and hold flag so a presented R beat is never retracted.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q   <= LFSR_SEED;
      r_hold_q <= 1'b0;
    end else begin
      lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      r_hold_q <= r_valid && !mem_bus.r_ready;
    end
  end

  assign stall   = lfsr_q[0];
  assign r_valid = (state_q == StRdBeat) && (r_hold_q || !stall);
`else
  assign stall   = 1'b0;
  assign r_valid = (state_q == StRdBeat);
`endif

  // Channel readies: IDLE arbitration alternates on simultaneous requests.
  always_comb begin
    ar_ready = 1'b0;
    aw_ready = 1'b0;
    if (state_q == StIdle && !stall) begin
      ar_ready = mem_bus.ar_valid && (!mem_bus.aw_valid || !last_grant_q);
      aw_ready = mem_bus.aw_valid && (!mem_bus.ar_valid || last_grant_q);
    end
  end

  assign w_ready = (state_q == StWrData) && !stall;
  assign b_valid = (state_q == StWrResp);
  assign r_hs    = r_valid && mem_bus.r_ready;
  assign w_hs    = mem_bus.w_valid && w_ready;
  assign mem_we  = w_hs && in_range;

  // Next-state and transaction bookkeeping.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    decerr_d     = decerr_q;
    slverr_d     = slverr_q;
    unique case (state_q)
      StIdle: begin
        if (aw_ready) begin
          id_d         = mem_bus.aw_id;
          addr_d       = mem_bus.aw_addr;
          len_d        = mem_bus.aw_len;
          size_d       = mem_bus.aw_size;
          burst_d      = mem_bus.aw_burst;
          beat_d       = 4'd0;
          decerr_d     = 1'b0;
          slverr_d     = 1'b0;
          last_grant_d = 1'b0;
          state_d      = StWrData;
        end else if (ar_ready) begin
          id_d         = mem_bus.ar_id;
          addr_d       = mem_bus.ar_addr;
          len_d        = mem_bus.ar_len;
          size_d       = mem_bus.ar_size;
          burst_d      = mem_bus.ar_burst;
          beat_d       = 4'd0;
          cnt_d        = 4'(RD_LAT);
          last_grant_d = 1'b1;
          state_d      = (RD_LAT == 0) ? StRdBeat : StRdWait;
        end
      end
      StRdWait: begin
        if (cnt_q <= 4'd1) state_d = StRdBeat;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StRdBeat: begin
        if (r_hs) begin
          if (beat_q == len_q) begin
            state_d = StIdle;
          end else begin
            addr_d = next_addr;
            beat_d = beat_q + 4'd1;
          end
        end
      end
      StWrData: begin
        if (w_hs) begin
          if (!in_range) decerr_d = 1'b1;
          // w_last must mark exactly the final beat.
          if ((beat_q == len_q) != mem_bus.w_last) slverr_d = 1'b1;
          if (beat_q == len_q) begin
            state_d = StWrResp;
          end else begin
            addr_d = next_addr;
            beat_d = beat_q + 4'd1;
          end
        end
      end
      StWrResp: begin
        if (mem_bus.b_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset abandons any burst without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      id_q         <= 4'd0;
      addr_q       <= 32'd0;
      len_q        <= 4'd0;
      size_q       <= 3'd0;
      burst_q      <= BurstFixed;
      beat_q       <= 4'd0;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      decerr_q     <= 1'b0;
      slverr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      decerr_q     <= decerr_d;
      slverr_q     <= slverr_d;
    end
  end

  // Byte-lane writes into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_bus.w_strb[b]) mem[word_idx][8*b +: 8] <= mem_bus.w_data[8*b +: 8];
      end
    end
  end

  assign mem_bus.ar_ready = ar_ready;
  assign mem_bus.aw_ready = aw_ready;
  assign mem_bus.w_ready  = w_ready;
  assign mem_bus.b_valid  = b_valid;
  assign mem_bus.b_id     = id_q;
  assign mem_bus.b_resp   = decerr_q ? RespDecerr : (slverr_q ? RespSlverr : RespOkay);
  assign mem_bus.r_valid  = r_valid;
  assign mem_bus.r_id     = id_q;
  assign mem_bus.r_data   = (r_valid && in_range) ? mem[word_idx] : 32'd0;
  assign mem_bus.r_resp   = (r_valid && !in_range) ? RespDecerr : RespOkay;
  assign mem_bus.r_last   = r_valid && (beat_q == len_q);

  logic unused_sideband;
  assign unused_sideband = ^{mem_bus.aw_lock, mem_bus.aw_cache, mem_bus.aw_prot, mem_bus.aw_qos,
                             mem_bus.ar_lock, mem_bus.ar_cache, mem_bus.ar_prot, mem_bus.ar_qos};

endmodule

// File: doc/axi_sram_responder.md
# axi_sram_responder

AXI3-style slave that terminates the core's external memory bus and answers the instruction/data cache traffic from the 2x1 master crossbar out of an on-chip word array. It is the simulation and FPGA-bring-up memory endpoint for the core. It handles single and burst reads and writes (FIXED/INCR/WRAP), echoes IDs, and reports out-of-range accesses with DECERR. It serves one transaction at a time.

## Interface
- DEPTH, 16384 — memory size in 32-bit words; power of two.
- BASE_ADDR, 32'h1c00_0000 — byte address mapped to word 0.
- RD_LAT, 1 — extra cycles between AR handshake and first R beat; range 0..15.
- LFSR_SEED, 16'hACE1 — stall generator seed; used only when the stall macro is defined.
- clk  in  1  — sole clock; everything on rising edge.
- rst  in  1  — synchronous, active-high reset.
- mem_bus  LA_AXI_BUS.Slave  —  carries the following fields:
  - id 4b, addr 32b, data 32b, strb 4b, len 4b (beats = len+1), size 3b, burst 2b, resp 2b.
  - lock/cache/prot/qos are accepted and ignored.

## Operation
- FSM states: IDLE, RD_WAIT, RD_BEAT, WR_DATA, WR_RESP.
- Ready signals:
  - IDLE: ar_ready/aw_ready are combinational from state and valids. All other states: both low.
  - Arbitration when ar_valid and aw_valid arrive together: alternate via a 1-bit last_grant register.
  - After reset, write wins first.
- AR handshake:
  - Latches id, addr, len, size, burst.
  - Goes to RD_WAIT with counter = RD_LAT, or straight to RD_BEAT when RD_LAT = 0.
- RD_BEAT:
  - r_valid = 1; r_data = mem[word index]; r_id = latched id; r_last = (beat == len).
  - All R outputs hold stable until r_ready.
  - Each r_valid&&r_ready advances the address. The r_last beat returns to IDLE.
- AW handshake:
  - Latches id, addr, len, size, burst; goes to WR_DATA.
  - w_ready = 1 in WR_DATA.
  - Each w_valid&&w_ready writes the byte lanes selected by w_strb, then advances the address.
  - On beat == len, goes to WR_RESP regardless of w_last.
- WR_RESP: b_valid = 1, b_id = latched id; held until b_ready, then IDLE.
- Address generation (increment = 1<<size):
  - FIXED: address is unchanged.
  - INCR: addr + increment.
  - WRAP: wrap boundary is (len+1)<<size bytes. Next addr = (addr & ~(boundary-1)) | ((addr + increment) & (boundary-1)). WRAP with len not in {1,3,7,15} behaves as INCR.
  - Word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
- Range check, per beat:
  - Out-of-range beats: addr < BASE_ADDR or addr >= BASE_ADDR + 4*DEPTH.
  - Out-of-range reads: r_data = 0, r_resp = DECERR.
  - Out-of-range writes: dropped, and the burst's b_resp = DECERR (sticky).
- Write burst errors: w_last missing on the final beat, or asserted early, gives b_resp = SLVERR unless DECERR is already set. DECERR has priority.
- Reset:
  - Mid-burst reset: abandons the burst and returns to IDLE. No B or R response is issued.
  - Memory contents are not reset.
  - Outputs after reset: r_valid, b_valid, w_ready = 0; r_last = 0; r_resp/b_resp = OKAY; r_id/b_id = 0; r_data = 0.

## Timing
- Read latency: AR handshake at edge T gives first r_valid at cycle T+1+RD_LAT. With r_ready held high, one beat per cycle follows.
- Write: w_ready rises the cycle after the AW handshake. b_valid rises the cycle after the final W handshake.
- Read-after-write: a new AR is accepted the cycle after b_ready, and sees the written data.
- Back-to-back transactions: minimum one IDLE cycle between transactions.

## Configuration
- Macro: AXI_SRAM_RAND_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with LFSR_SEED at reset, steps every cycle.
  - When LFSR bit 0 = 1: ar_ready, aw_ready and w_ready are forced low, and a new R beat is withheld.
  - An already asserted r_valid/b_valid is never dropped.
- When undefined: no stalls; timing is exactly as in Timing.

## Structure
- Package la_axi_pkg:
  - Burst encodings FIXED=0, INCR=1, WRAP=2.
  - Resp codes OKAY=0, SLVERR=2, DECERR=3.
  - FSM state enum.
- Sub-module axi_burst_addr_gen: combinational next-address from addr/size/len/burst. Shared with future AXI slaves.
- Memory array inferred inline; reads combinational from the registered address.

## Test plan
- INCR write, AW addr 0x1c000000 len 3, data 0x11..0x44, strb 4'hF → b_resp OKAY, b_id echoed. INCR read of the same → r_data 0x11,0x22,0x33,0x44 with r_last on beat 3 only.
- WRAP read, addr 0x1c000008 len 3 → word order 2,3,0,1.
- Strobe write 0xAABBCCDD with strb 4'b0101 over 0x00000000 → read returns 0x00BB00DD.
- Simultaneous ar_valid/aw_valid straight after reset → AW granted first. The next simultaneous pair → AR granted.
- Out-of-range cases, with RD_LAT=3:
  - Read at 0x1c000000 + 4*DEPTH → r_resp DECERR, data 0, first r_valid 4 cycles after the handshake.
  - Write with early w_last → SLVERR.
- Reset asserted during beat 2 of a len-7 read → r_valid low the next cycle, FSM in IDLE. A subsequent read returns the previously written data.
